burst_rr_arbiter: RTL and testbench

BURST_RR_ARBITER -- requirements
Module: burst_rr_arbiter

---
 rtl/burst_rr_arbiter.sv | 95 +++++++++
 tb/tb_burst_rr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter: round-robin arbiter that holds a grant for a whole burst
module burst_rr_arbiter #(
    parameter int nReq      = 4,
    parameter int DataWidth = 32,
    parameter int IdWidth   = $clog2(nReq)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [nReq-1:0]           in_valid,
    input  logic [nReq-1:0]           in_last,
    input  logic [nReq*DataWidth-1:0] in_data,
    output logic [nReq-1:0]           in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [DataWidth-1:0]      out_data,
    output logic [IdWidth-1:0]        out_id,
    output logic                      busy,
    output logic [15:0]               beat_count
);
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q;
    logic [IdWidth-1:0] owner_q;
    logic [IdWidth-1:0] last_q;
    logic [15:0]        cnt_q;
    logic [IdWidth-1:0] idx_m;
    logic [IdWidth-1:0] idx_a;
    logic               hit_m;
    logic               hit_a;
    logic [IdWidth-1:0] sel;
    logic               act;
    logic               fire;

    // Lowest valid index above the last owner, else lowest valid overall; the lock overrides both.
    always_comb begin
        idx_m = '0;
        idx_a = '0;
        hit_m = 1'b0;
        hit_a = 1'b0;
        for (int i = nReq - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                idx_a = IdWidth'(i);
                hit_a = 1'b1;
                if (IdWidth'(i) > last_q) begin
                    idx_m = IdWidth'(i);
                    hit_m = 1'b1;
                end
            end
        end
        sel = (state_q == LOCKED) ? owner_q : hit_m ? idx_m : idx_a;
        act = reset_n && ((state_q == LOCKED) || hit_a);
    end

    // Forward the selected requester and route out_ready back to it alone.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        in_ready  = '0;
        for (int i = 0; i < nReq; i++) begin
            if (sel == IdWidth'(i)) begin
                out_valid   = act && in_valid[i];
                out_last    = in_last[i];
                out_data    = in_data[i*DataWidth +: DataWidth];
                in_ready[i] = act && out_ready;
            end
        end
    end

    assign out_id     = sel;
    assign fire       = out_valid && out_ready;
    assign busy       = (state_q == LOCKED);
    assign beat_count = cnt_q;

    // Burst FSM: lock on a non-last beat, release and move the pointer on the last one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IdWidth'(nReq - 1);
            cnt_q   <= '0;
        end else if (fire) begin
            if (out_last) begin
                state_q <= IDLE;
                last_q  <= sel;
                cnt_q   <= '0;
            end else begin
                state_q <= LOCKED;
                owner_q <= sel;
                cnt_q   <= (&cnt_q) ? cnt_q : cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_burst_rr_arbiter.sv
// tb_burst_rr_arbiter: scoreboard bench for burst_rr_arbiter
module tb_burst_rr_arbiter;
    logic         clock;
    logic         reset_n;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
    logic         busy;
    logic [15:0]  beat_count;

    typedef struct packed {
        logic [1:0]  id;
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    burst_rr_arbiter dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_data(out_data), .out_id(out_id), .busy(busy),
        .beat_count(beat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pay(input int r, input int b);
        return {8'hA5, r[7:0], b[15:0]};
    endfunction

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input int b);
        in_valid = v;
        in_last  = l;
        for (int r = 0; r < 4; r++) in_data[r*32 +: 32] = pay(r, b);
    endtask

    task automatic xp(input int id, input int last, input int b);
        exp_t e;
        e.id   = id[1:0];
        e.last = last[0];
        e.data = pay(id, b);
        exp_q.push_back(e);
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    // Every accepted output beat must match the oldest expected transfer.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_id", out_id, e.id);
                chk("sb_data", out_data, e.data);
                chk("sb_last", out_last, e.last);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive(4'b0000, 4'b0000, 0);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", beat_count, 0);
        chk("idle_out_id", out_id, 0);
        drive(4'b1111, 4'b1111, 0);
        #1;
        chk("rst_gate_valid", out_valid, 0);
        chk("rst_gate_ready", in_ready, 0);
        drive(4'b0000, 4'b0000, 0);
        cyc;
        cyc;
        reset_n = 1'b1;
        #1;
        chk("idle_ready", in_ready, 0);
        chk("idle_valid", out_valid, 0);
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 4'b1111, k);
            xp(k % 4, 1, k);
            cyc;
            chk("rr_busy", busy, 0);
        end
        drive(4'b0000, 4'b0000, 0);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0111, (k == 2) ? 4'b0111 : 4'b0101, k);
            xp(1, (k == 2) ? 1 : 0, k);
            #1;
            chk("burst_ready", in_ready, 4'b0010);
            cyc;
            chk("burst_busy", busy, (k < 2) ? 1 : 0);
            chk("burst_count", beat_count, (k < 2) ? k + 1 : 0);
        end
        drive(4'b0111, 4'b0111, 3);
        xp(2, 1, 3);
        cyc;
        drive(4'b0100, 4'b0000, 0);
        xp(2, 0, 0);
        cyc;
        chk("bub_busy0", busy, 1);
        for (int k = 0; k < 2; k++) begin
            drive(4'b1000, 4'b1000, k);
            #1;
            chk("bub_valid", out_valid, 0);
            chk("bub_ready3", in_ready[3], 0);
            chk("bub_id", out_id, 2);
            cyc;
            chk("bub_busy", busy, 1);
            chk("bub_count", beat_count, 1);
        end
        drive(4'b1100, 4'b1100, 1);
        xp(2, 1, 1);
        cyc;
        chk("bub_end_busy", busy, 0);
        drive(4'b1000, 4'b1000, 2);
        xp(3, 1, 2);
        cyc;
        drive(4'b0001, 4'b0000, 0);
        xp(0, 0, 0);
        cyc;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 4'b0000, 1);
            #1;
            chk("stall_id", out_id, 0);
            chk("stall_ready", in_ready, 0);
            cyc;
            chk("stall_count", beat_count, 1);
            chk("stall_busy", busy, 1);
        end
        out_ready = 1'b1;
        drive(4'b1111, 4'b0001, 1);
        xp(0, 1, 1);
        cyc;
        chk("stall_end_count", beat_count, 0);
        drive(4'b1111, 4'b1111, 2);
        xp(1, 1, 2);
        cyc;
        for (int k = 0; k < 2; k++) begin
            drive(4'b1000, 4'b0000, k);
            xp(3, 0, k);
            cyc;
        end
        chk("mid_busy", busy, 1);
        chk("mid_count", beat_count, 2);
        reset_n = 1'b0;
        drive(4'b1111, 4'b1111, 9);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", beat_count, 0);
        chk("mid_rst_valid", out_valid, 0);
        cyc;
        reset_n = 1'b1;
        xp(0, 1, 9);
        cyc;
        for (int k = 0; k < 70000; k++) begin
            drive(4'b0010, (k == 69999) ? 4'b0010 : 4'b0000, k);
            xp(1, (k == 69999) ? 1 : 0, k);
            if (k == 65534) chk("sat_pre", beat_count, 16'hFFFE);
            if (k == 65535) chk("sat_hit", beat_count, 16'hFFFF);
            if (k == 69999) begin
                chk("sat_hold", beat_count, 16'hFFFF);
                chk("sat_busy", busy, 1);
            end
            cyc;
        end
        chk("sat_end_count", beat_count, 0);
        chk("sat_end_busy", busy, 0);
        drive(4'b0000, 4'b0000, 0);
        cyc;
        chk("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
